// File: rtl/cur_block_buffer.sv
// -----------------------------------------------------------------------------
// cur_block_buffer
//
// Current-block buffer for the motion-estimation datapath. Packs a narrow
// pixel stream (IN_PIX pixels per word) into a flat block image and presents
// the whole block in parallel to the SAD array.
//
// Optional feature macro: CUR_BUF_DBL_EN
//   defined   -> two banks (ping-pong). The next block loads while the
//                present one is searched.
//   undefined -> one bank. Loading waits until the active block is released.
//
// Handshake: a word is accepted on a rising edge where need_cur (ready) and
// cur_in_valid (valid) are both high. need_cur does not depend on
// cur_in_valid. A word offered while need_cur=0 stays with the producer.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset; clears state and contents
//   cur_in       in   input word; pixel j at [j*PIX_W +: PIX_W]
//   cur_in_valid in   cur_in carries a word
//   need_cur     out  buffer accepts a word this cycle
//   next_block   in   one-cycle pulse: consumer has finished with active block
//   cur_out      out  active block; pixel row*BLK_W+col at [idx*PIX_W +: PIX_W]
//   cur_valid    out  cur_out holds a complete block
//   drop_err     out  one-cycle pulse: next_block arrived while cur_valid=0
// -----------------------------------------------------------------------------
module cur_block_buffer #(
  parameter int PIX_W  = 8,
  parameter int BLK_W  = 8,
  parameter int BLK_H  = 8,
  parameter int IN_PIX = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [IN_PIX*PIX_W-1:0]        cur_in,
  input  logic                           cur_in_valid,
  output logic                           need_cur,
  input  logic                           next_block,
  output logic [BLK_W*BLK_H*PIX_W-1:0]   cur_out,
  output logic                           cur_valid,
  output logic                           drop_err
);

  localparam int WORDS    = BLK_W * BLK_H / IN_PIX;
  localparam int WORD_W   = IN_PIX * PIX_W;
  localparam int BLK_BITS = WORDS * WORD_W;
  localparam int WCNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

`ifdef CUR_BUF_DBL_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [BLK_BITS-1:0] r_bank [NB];
  logic [NB-1:0]       r_full;
  logic [NB-1:0]       w_full_nxt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_drop_err;
  logic                w_wbank;
  logic                w_rbank;
  logic                w_accept;
  logic                w_last;
  logic                w_release;

  assign need_cur  = ~r_full[w_wbank];
  assign cur_valid = r_full[w_rbank];
  assign cur_out   = r_bank[w_rbank];
  assign drop_err  = r_drop_err;

  assign w_accept  = need_cur & cur_in_valid;
  assign w_last    = (r_wcnt == LAST_WORD);
  assign w_release = next_block & cur_valid;

  // Fill and release can hit in the same cycle; with two banks they always
  // target different banks, with one bank they are mutually exclusive
  // (accept needs the bank empty, release needs it full).
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && w_last) w_full_nxt[w_wbank] = 1'b1;
    if (w_release)          w_full_nxt[w_rbank] = 1'b0;
  end

`ifdef CUR_BUF_DBL_EN
  logic r_wbank;
  logic r_rbank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
    end else begin
      if (w_accept && w_last) r_wbank <= ~r_wbank;
      if (w_release)          r_rbank <= ~r_rbank;
    end
  end

  assign w_wbank = r_wbank;
  assign w_rbank = r_rbank;
`else
  assign w_wbank = 1'b0;
  assign w_rbank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= '0;
      r_wcnt     <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_drop_err <= next_block & ~cur_valid;
      if (w_accept) begin
        if (w_last) r_wcnt <= '0;
        else        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  // Contents are cleared on reset so cur_out reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) r_bank[b] <= '0;
    end else if (w_accept) begin
      r_bank[w_wbank][r_wcnt*WORD_W +: WORD_W] <= cur_in;
    end
  end

endmodule

// File: tb/tb_cur_block_buffer.sv
// -----------------------------------------------------------------------------
// tb_cur_block_buffer
//
// Directed bench for cur_block_buffer at default parameters. Builds with or
// without CUR_BUF_DBL_EN; the ping-pong section runs only when it is defined,
// the single-bank backpressure section only when it is not.
// -----------------------------------------------------------------------------
module tb_cur_block_buffer;

  localparam int OUT_W = 512;
  localparam int WORDS = 16;

  logic             clk;
  logic             rst_n;
  logic [31:0]      cur_in;
  logic             cur_in_valid;
  logic             need_cur;
  logic             next_block;
  logic [OUT_W-1:0] cur_out;
  logic             cur_valid;
  logic             drop_err;

  int n_cmp;
  int n_err;

  logic [7:0]       exp_q[$];
  logic [OUT_W-1:0] exp_blk;

  cur_block_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cur_in       (cur_in),
    .cur_in_valid (cur_in_valid),
    .need_cur     (need_cur),
    .next_block   (next_block),
    .cur_out      (cur_out),
    .cur_valid    (cur_valid),
    .drop_err     (drop_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [OUT_W-1:0] obs,
                          input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [7:0] base,
                                     input logic [7:0] step, input int idx);
    return 8'(int'(base) + int'(step) * idx);
  endfunction

  // Take the next 64 queued pixels as the block expected on cur_out.
  task automatic pop_block();
    exp_blk = '0;
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() > 0) exp_blk[i*8 +: 8] = exp_q.pop_front();
    end
  endtask

  // ---------------- driver ----------------
  task automatic push_word(input logic [31:0] w);
    int n;
    cur_in       = w;
    cur_in_valid = 1'b1;
    n = 0;
    while (!need_cur && n < 100) begin
      tick();
      n++;
    end
    check_eq("need_cur_wait", OUT_W'(need_cur), OUT_W'(1));
    tick();
  endtask

  task automatic load_words(input logic [7:0] base, input logic [7:0] step,
                            input bit gap, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      logic [31:0] w;
      for (int j = 0; j < 4; j++) begin
        w[j*8 +: 8] = pix(base, step, k*4 + j);
        exp_q.push_back(w[j*8 +: 8]);
      end
      push_word(w);
      if (gap) begin
        cur_in_valid = 1'b0;
        tick();
      end
    end
    cur_in_valid = 1'b0;
  endtask

  task automatic pulse_next();
    next_block = 1'b1;
    tick();
    next_block = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    cur_in       = '0;
    cur_in_valid = 1'b0;
    next_block   = 1'b0;
    exp_blk      = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check_eq("rst_cur_out",   cur_out,          '0);
    check_eq("rst_need_cur",  OUT_W'(need_cur),  OUT_W'(1));
    check_eq("rst_cur_valid", OUT_W'(cur_valid), OUT_W'(0));
    check_eq("rst_drop_err",  OUT_W'(drop_err),  OUT_W'(0));

    // next_block with nothing valid: one-cycle drop_err, state unchanged
    pulse_next();
    check_eq("drop_err_hi",   OUT_W'(drop_err),  OUT_W'(1));
    check_eq("drop_cur_valid",OUT_W'(cur_valid), OUT_W'(0));
    check_eq("drop_need_cur", OUT_W'(need_cur),  OUT_W'(1));
    tick();
    check_eq("drop_err_lo",   OUT_W'(drop_err),  OUT_W'(0));

    // bytes 0x00..0x3F, continuous valid
    load_words(8'h00, 8'h01, 1'b0, 0, 14);
    check_eq("fill15_cur_valid", OUT_W'(cur_valid), OUT_W'(0));
    load_words(8'h00, 8'h01, 1'b0, 15, 15);
    pop_block();
    check_eq("fill_cur_valid", OUT_W'(cur_valid), OUT_W'(1));
    check_eq("fill_block",     cur_out,           exp_blk);
    check_eq("fill_px0",       OUT_W'(cur_out[7:0]),     OUT_W'(8'h00));
    check_eq("fill_px1",       OUT_W'(cur_out[15:8]),    OUT_W'(8'h01));
    check_eq("fill_px63",      OUT_W'(cur_out[511:504]), OUT_W'(8'h3F));

`ifdef CUR_BUF_DBL_EN
    check_eq("dbl_need_cur_free", OUT_W'(need_cur), OUT_W'(1));
    pulse_next();
    check_eq("dbl_rel1_valid", OUT_W'(cur_valid), OUT_W'(0));

    // block A (0x11) then block B (0x22)
    load_words(8'h11, 8'h00, 1'b0, 0, WORDS-1);
    pop_block();
    check_eq("dbl_A_block",    cur_out,          exp_blk);
    check_eq("dbl_A_need_cur", OUT_W'(need_cur), OUT_W'(1));
    load_words(8'h22, 8'h00, 1'b0, 0, WORDS-1);
    check_eq("dbl_B_need_cur", OUT_W'(need_cur), OUT_W'(0));
    check_eq("dbl_B_still_A",  cur_out,          exp_blk);
    pulse_next();
    pop_block();
    check_eq("dbl_swap_valid",    OUT_W'(cur_valid), OUT_W'(1));
    check_eq("dbl_swap_block",    cur_out,           exp_blk);
    check_eq("dbl_swap_need_cur", OUT_W'(need_cur),  OUT_W'(1));

    // block C, release in the same cycle as its final word
    load_words(8'h33, 8'h02, 1'b0, 0, WORDS-2);
    next_block = 1'b1;
    load_words(8'h33, 8'h02, 1'b0, WORDS-1, WORDS-1);
    next_block = 1'b0;
    pop_block();
    check_eq("sim_valid",    OUT_W'(cur_valid), OUT_W'(1));
    check_eq("sim_block",    cur_out,           exp_blk);
    check_eq("sim_need_cur", OUT_W'(need_cur),  OUT_W'(1));
    pulse_next();
    check_eq("sim_rel_valid", OUT_W'(cur_valid), OUT_W'(0));
`else
    // backpressure: extra words offered while full are not taken
    cur_in       = 32'hDEADBEEF;
    cur_in_valid = 1'b1;
    repeat (3) tick();
    check_eq("bp_need_cur",  OUT_W'(need_cur),  OUT_W'(0));
    check_eq("bp_cur_valid", OUT_W'(cur_valid), OUT_W'(1));
    check_eq("bp_block",     cur_out,           exp_blk);
    cur_in_valid = 1'b0;
    pulse_next();
    check_eq("rel_cur_valid", OUT_W'(cur_valid), OUT_W'(0));
    check_eq("rel_need_cur",  OUT_W'(need_cur),  OUT_W'(1));
    check_eq("rel_drop_err",  OUT_W'(drop_err),  OUT_W'(0));
`endif

    // gapped input, pixel order must hold
    load_words(8'h40, 8'h01, 1'b1, 0, WORDS-1);
    pop_block();
    check_eq("gap_cur_valid", OUT_W'(cur_valid), OUT_W'(1));
    check_eq("gap_block",     cur_out,           exp_blk);
    pulse_next();
    check_eq("gap_rel_valid", OUT_W'(cur_valid), OUT_W'(0));

    // reset after 7 words discards the partial block
    load_words(8'h80, 8'h01, 1'b0, 0, 6);
    check_eq("part_cur_valid", OUT_W'(cur_valid), OUT_W'(0));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("mrst_cur_out",   cur_out,           '0);
    check_eq("mrst_need_cur",  OUT_W'(need_cur),  OUT_W'(1));
    check_eq("mrst_cur_valid", OUT_W'(cur_valid), OUT_W'(0));
    tick();
    rst_n = 1'b1;
    tick();
    load_words(8'hA0, 8'h03, 1'b0, 0, WORDS-1);
    pop_block();
    check_eq("post_rst_valid", OUT_W'(cur_valid), OUT_W'(1));
    check_eq("post_rst_block", cur_out,           exp_blk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
